fft8_core: RTL and testbench

- 8-point radix-2 decimation-in-time complex FFT on 16-bit signed Q8.8 data (8 integer bits, 8 fractional bits).
- Sits as a register-mapped compute block: the host drives all 8 complex inputs in parallel, pulses write and then start, and reads 8 complex outputs in parallel once ready is high.
- Fixed-function core with a 2-bit state output exposed for debug.

---
 rtl/fft8_pkg.sv | 38 +++
 rtl/fft8_butterfly.sv | 45 ++++
 rtl/fft8_core.sv | 171 +++++++++++++++++
 tb/tb_fft8_core.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/fft8_pkg.sv
// Shared constants for the 8-point FFT core: word sizes, FSM encoding, twiddles, bit-reverse order.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package fft8_pkg;

  localparam int DW   = 16;
  localparam int FRAC = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    LOAD    = 2'b01,
    COMPUTE = 2'b10,
    DONE    = 2'b11
  } state_t;

  // Working-register slot n holds input sample BITREV[n].
  localparam logic [2:0] BITREV [8] = '{3'd0, 3'd4, 3'd2, 3'd6, 3'd1, 3'd5, 3'd3, 3'd7};

  // Twiddles W_8^k in Q8.8: W0=(256,0) W1=(181,-181) W2=(0,-256) W3=(-181,-181).
  function automatic logic signed [DW-1:0] tw_re(input logic [1:0] k);
    case (k)
      2'd0:    tw_re = 16'sd256;
      2'd1:    tw_re = 16'sd181;
      2'd2:    tw_re = '0;
      default: tw_re = -16'sd181;
    endcase
  endfunction

  function automatic logic signed [DW-1:0] tw_im(input logic [1:0] k);
    case (k)
      2'd0:    tw_im = '0;
      2'd1:    tw_im = -16'sd181;
      2'd2:    tw_im = -16'sd256;
      default: tw_im = -16'sd181;
    endcase
  endfunction

endpackage

// File: rtl/fft8_butterfly.sv
// Radix-2 DIT butterfly: t = b*w (Q8.8, floor), a' = a + t, b' = a - t, all with 16-bit wrap.
// Latency: purely combinational.
// Backpressure: none; operands are consumed every cycle by the parent.
module fft8_butterfly #(
  parameter int DW   = 16,
  parameter int FRAC = 8
) (
  input  logic signed [DW-1:0] a_re_i,
  input  logic signed [DW-1:0] a_im_i,
  input  logic signed [DW-1:0] b_re_i,
  input  logic signed [DW-1:0] b_im_i,
  input  logic signed [DW-1:0] w_re_i,
  input  logic signed [DW-1:0] w_im_i,
  output logic signed [DW-1:0] a_out_re_o,
  output logic signed [DW-1:0] a_out_im_o,
  output logic signed [DW-1:0] b_out_re_o,
  output logic signed [DW-1:0] b_out_im_o
);

  // One spare bit so the sum of two full-scale products cannot overflow.
  logic signed [2*DW:0] bre_x, bim_x, wre_x, wim_x;
  logic signed [2*DW:0] prod_re, prod_im;
  logic signed [DW-1:0] t_re, t_im;
  logic                 unused_prod_bits;

  // Complex multiply, floor-shift by FRAC, then add/subtract with natural wrap.
  always_comb begin
    bre_x   = {{(DW+1){b_re_i[DW-1]}}, b_re_i};
    bim_x   = {{(DW+1){b_im_i[DW-1]}}, b_im_i};
    wre_x   = {{(DW+1){w_re_i[DW-1]}}, w_re_i};
    wim_x   = {{(DW+1){w_im_i[DW-1]}}, w_im_i};
    prod_re = bre_x * wre_x - bim_x * wim_x;
    prod_im = bre_x * wim_x + bim_x * wre_x;
    // Taking bits [FRAC+DW-1:FRAC] is an arithmetic right shift followed by narrowing.
    t_re    = prod_re[FRAC +: DW];
    t_im    = prod_im[FRAC +: DW];
    a_out_re_o = a_re_i + t_re;
    a_out_im_o = a_im_i + t_im;
    b_out_re_o = a_re_i - t_re;
    b_out_im_o = a_im_i - t_im;
    unused_prod_bits = ^{prod_re[2*DW:FRAC+DW], prod_re[FRAC-1:0],
                         prod_im[2*DW:FRAC+DW], prod_im[FRAC-1:0]};
  end

endmodule

// File: rtl/fft8_core.sv
// 8-point radix-2 DIT complex FFT, Q8.8, register-mapped: write latches inputs, start runs 3 stages.
// Latency: ready rises 3 clocks after state first reads COMPUTE (one butterfly stage per clock).
// Backpressure: none; DONE holds while start stays high, y holds until the next completed run.
module fft8_core #(
  parameter int DW   = fft8_pkg::DW,
  parameter int FRAC = fft8_pkg::FRAC
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          write,
  input  logic          start,
  input  logic [DW-1:0] x0r, x0i, x1r, x1i, x2r, x2i, x3r, x3i,
  input  logic [DW-1:0] x4r, x4i, x5r, x5i, x6r, x6i, x7r, x7i,
  output logic [DW-1:0] y0r, y0i, y1r, y1i, y2r, y2i, y3r, y3i,
  output logic [DW-1:0] y4r, y4i, y5r, y5i, y6r, y6i, y7r, y7i,
  output logic          ready,
  output logic [1:0]    state
);
  import fft8_pkg::*;

  state_t               state_q, state_d;
  logic [1:0]           stg_q, stg_d;
  logic signed [DW-1:0] xr [8], xi [8];
  logic signed [DW-1:0] wr_q [8], wi_q [8], wr_d [8], wi_d [8];
  logic signed [DW-1:0] yr_q [8], yi_q [8], yr_d [8], yi_d [8];
  logic signed [DW-1:0] ar [4], ai [4], br [4], bi [4], twr [4], twi [4];
  logic signed [DW-1:0] aor [4], aoi [4], bor [4], boi [4];
  logic signed [DW-1:0] sr [8], si [8];
  logic [1:0]           jj, tw_idx, sel_j;
  logic [2:0]           top_idx, bot_idx, pos;
  logic                 sel_b;

  assign xr = '{x0r, x1r, x2r, x3r, x4r, x5r, x6r, x7r};
  assign xi = '{x0i, x1i, x2i, x3i, x4i, x5i, x6i, x7i};

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // FSM next state: start beats write in LOAD, DONE waits for start to drop.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (write) state_d = LOAD;
      LOAD:    if (start) state_d = COMPUTE;
      COMPUTE: if (stg_q == 2'd2) state_d = DONE;
      DONE:    if (!start) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Butterfly j pairs (top, top+span) for the current stage and picks its twiddle.
  always_comb begin
    jj = '0; top_idx = '0; bot_idx = '0; tw_idx = '0;
    for (int j = 0; j < 4; j++) begin
      jj = 2'(j);
      case (stg_q)
        2'd0: begin
          top_idx = {jj, 1'b0};        bot_idx = {jj, 1'b1};        tw_idx = 2'd0;
        end
        2'd1: begin
          top_idx = {jj[1], 1'b0, jj[0]}; bot_idx = {jj[1], 1'b1, jj[0]}; tw_idx = {jj[0], 1'b0};
        end
        default: begin
          top_idx = {1'b0, jj};        bot_idx = {1'b1, jj};        tw_idx = jj;
        end
      endcase
      ar[j]  = wr_q[top_idx];
      ai[j]  = wi_q[top_idx];
      br[j]  = wr_q[bot_idx];
      bi[j]  = wi_q[bot_idx];
      twr[j] = tw_re(tw_idx);
      twi[j] = tw_im(tw_idx);
    end
  end

  for (genvar j = 0; j < 4; j++) begin : g_bf
    fft8_butterfly #(.DW(DW), .FRAC(FRAC)) u_bf (
      .a_re_i     (ar[j]),
      .a_im_i     (ai[j]),
      .b_re_i     (br[j]),
      .b_im_i     (bi[j]),
      .w_re_i     (twr[j]),
      .w_im_i     (twi[j]),
      .a_out_re_o (aor[j]),
      .a_out_im_o (aoi[j]),
      .b_out_re_o (bor[j]),
      .b_out_im_o (boi[j])
    );
  end

  // Scatter butterfly outputs back to slot order: inverse of the pairing above.
  always_comb begin
    pos = '0; sel_j = '0; sel_b = 1'b0;
    for (int i = 0; i < 8; i++) begin
      pos = 3'(i);
      case (stg_q)
        2'd0:    begin sel_j = pos[2:1];         sel_b = pos[0]; end
        2'd1:    begin sel_j = {pos[2], pos[0]}; sel_b = pos[1]; end
        default: begin sel_j = pos[1:0];         sel_b = pos[2]; end
      endcase
      sr[i] = sel_b ? bor[sel_j] : aor[sel_j];
      si[i] = sel_b ? boi[sel_j] : aoi[sel_j];
    end
  end

  // Datapath next state: load inputs bit-reversed, run one stage per COMPUTE clock, publish on the last.
  always_comb begin
    wr_d  = wr_q;
    wi_d  = wi_q;
    yr_d  = yr_q;
    yi_d  = yi_q;
    stg_d = stg_q;
    case (state_q)
      IDLE, LOAD: begin
        if (state_q == LOAD && start) begin
          stg_d = 2'd0;
        end else if (write) begin
          for (int i = 0; i < 8; i++) begin
            wr_d[i] = xr[BITREV[i]];
            wi_d[i] = xi[BITREV[i]];
          end
        end
      end
      COMPUTE: begin
        wr_d  = sr;
        wi_d  = si;
        stg_d = stg_q + 2'd1;
        if (stg_q == 2'd2) begin
          yr_d = sr;
          yi_d = si;
        end
      end
      default: ;
    endcase
  end

  // Datapath registers; reset clears working data and results.
  always_ff @(posedge clk) begin
    if (rst) begin
      stg_q <= '0;
      for (int i = 0; i < 8; i++) begin
        wr_q[i] <= '0;
        wi_q[i] <= '0;
        yr_q[i] <= '0;
        yi_q[i] <= '0;
      end
    end else begin
      stg_q <= stg_d;
      wr_q  <= wr_d;
      wi_q  <= wi_d;
      yr_q  <= yr_d;
      yi_q  <= yi_d;
    end
  end

  assign ready = (state_q == DONE);
  assign state = state_q;

  assign y0r = yr_q[0]; assign y0i = yi_q[0];
  assign y1r = yr_q[1]; assign y1i = yi_q[1];
  assign y2r = yr_q[2]; assign y2i = yi_q[2];
  assign y3r = yr_q[3]; assign y3i = yi_q[3];
  assign y4r = yr_q[4]; assign y4i = yi_q[4];
  assign y5r = yr_q[5]; assign y5i = yi_q[5];
  assign y6r = yr_q[6]; assign y6i = yi_q[6];
  assign y7r = yr_q[7]; assign y7i = yi_q[7];

endmodule

// File: tb/tb_fft8_core.sv
// Directed bench for fft8_core with a scoreboard of hand-computed spectra.
// Stimulus pushes the expected spectrum on start; a monitor pops it when ready rises.
// FSM sequencing, latency, reset and hold behaviour are checked inline by the stimulus.
module tb_fft8_core;

  logic        clk = 1'b0;
  logic        rst, write, start;
  logic [15:0] xr [8];
  logic [15:0] xi [8];
  logic [15:0] yr [8];
  logic [15:0] yi [8];
  logic        ready;
  logic [1:0]  state;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [7:0]       tag;
    logic [7:0][15:0] er;
    logic [7:0][15:0] ei;
    logic [7:0][3:0]  tol;
  } exp_t;

  exp_t sb [$];
  logic ready_prev = 1'b0;

  fft8_core dut (
    .clk(clk), .rst(rst), .write(write), .start(start),
    .x0r(xr[0]), .x0i(xi[0]), .x1r(xr[1]), .x1i(xi[1]),
    .x2r(xr[2]), .x2i(xi[2]), .x3r(xr[3]), .x3i(xi[3]),
    .x4r(xr[4]), .x4i(xi[4]), .x5r(xr[5]), .x5i(xi[5]),
    .x6r(xr[6]), .x6i(xi[6]), .x7r(xr[7]), .x7i(xi[7]),
    .y0r(yr[0]), .y0i(yi[0]), .y1r(yr[1]), .y1i(yi[1]),
    .y2r(yr[2]), .y2i(yi[2]), .y3r(yr[3]), .y3i(yi[3]),
    .y4r(yr[4]), .y4i(yi[4]), .y5r(yr[5]), .y5i(yi[5]),
    .y6r(yr[6]), .y6i(yi[6]), .y7r(yr[7]), .y7i(yi[7]),
    .ready(ready), .state(state)
  );

  always #5 clk = ~clk;

  task automatic check_bin(input string name, input logic [15:0] got,
                           input logic [15:0] want, input int tol);
    int diff;
    checks++;
    diff = int'($signed(got)) - int'($signed(want));
    if ($isunknown(got) || diff > tol || diff < -tol) begin
      errors++;
      $display("FAIL %s got %0d want %0d (tol %0d)", name, $signed(got), $signed(want), tol);
    end
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got 0x%0h want 0x%0h", name, got, want);
    end
  endtask

  // Monitor: a rising ready means a result is presented; compare it against the oldest expectation.
  always @(negedge clk) begin
    if (ready === 1'b1 && ready_prev !== 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result ready rose with got 1 want no pending result");
      end else begin
        exp_t e;
        e = sb.pop_front();
        for (int k = 0; k < 8; k++) begin
          check_bin($sformatf("t%0d_y%0d_re", e.tag, k), yr[k], e.er[k], int'(e.tol[k]));
          check_bin($sformatf("t%0d_y%0d_im", e.tag, k), yi[k], e.ei[k], int'(e.tol[k]));
        end
      end
    end
    ready_prev = ready;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic scramble;
    for (int n = 0; n < 8; n++) begin
      xr[n] = 16'($urandom);
      xi[n] = 16'($urandom);
    end
  endtask

  task automatic check_y_zero(input string name);
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("%s_y%0d_re", name, k), 32'(yr[k]), 32'd0);
      chk($sformatf("%s_y%0d_im", name, k), 32'(yi[k]), 32'd0);
    end
  endtask

  // One full transaction: write, start (with a conflicting write), 3 compute clocks, DONE hold, release.
  task automatic run_fft(input logic [7:0][15:0] r, input logic [7:0][15:0] im, input exp_t e);
    for (int n = 0; n < 8; n++) begin
      xr[n] = r[n];
      xi[n] = im[n];
    end
    write = 1'b1; start = 1'b0;
    tick;
    chk($sformatf("t%0d_load_state", e.tag), 32'(state), 32'd1);
    scramble;
    write = 1'b1; start = 1'b1;
    sb.push_back(e);
    tick;
    chk($sformatf("t%0d_compute_state", e.tag), 32'(state), 32'd2);
    write = 1'b0; start = 1'b0;
    scramble;
    tick;
    chk($sformatf("t%0d_stage1_state", e.tag), 32'(state), 32'd2);
    scramble;
    tick;
    chk($sformatf("t%0d_stage2_state", e.tag), 32'(state), 32'd2);
    chk($sformatf("t%0d_ready_early", e.tag), 32'(ready), 32'd0);
    tick;
    chk($sformatf("t%0d_done_state", e.tag), 32'(state), 32'd3);
    chk($sformatf("t%0d_done_ready", e.tag), 32'(ready), 32'd1);
    start = 1'b1;
    tick;
    chk($sformatf("t%0d_done_hold", e.tag), 32'(state), 32'd3);
    start = 1'b0;
    tick;
    chk($sformatf("t%0d_back_idle", e.tag), 32'(state), 32'd0);
    chk($sformatf("t%0d_idle_ready", e.tag), 32'(ready), 32'd0);
    chk($sformatf("t%0d_y0_held", e.tag), 32'(yr[0]), 32'(e.er[0]));
  endtask

  function automatic exp_t flat_exp(input logic [7:0] tag, input logic [15:0] re0,
                                    input logic [15:0] rest_re);
    exp_t e;
    e.tag = tag;
    for (int k = 0; k < 8; k++) begin
      e.er[k]  = (k == 0) ? re0 : rest_re;
      e.ei[k]  = 16'h0000;
      e.tol[k] = 4'd0;
    end
    return e;
  endfunction

  logic [7:0][15:0] vr, vi;
  exp_t             ex;

  initial begin
    rst = 1'b1; write = 1'b1; start = 1'b1;
    scramble;
    tick;
    tick;
    chk("reset_state", 32'(state), 32'd0);
    chk("reset_ready", 32'(ready), 32'd0);
    check_y_zero("reset");
    rst = 1'b0; write = 1'b0; start = 1'b0;
    tick;
    chk("idle_after_reset", 32'(state), 32'd0);

    // start alone must not leave IDLE
    start = 1'b1;
    tick;
    tick;
    chk("start_without_write", 32'(state), 32'd0);
    start = 1'b0;

    // Ramp: x_n = n. X0=28, X4=-4, X2=-4+4j, X6=-4-4j, odd bins -4 +/- j*(9.657|1.657).
    for (int n = 0; n < 8; n++) begin vr[n] = 16'(n * 256); vi[n] = 16'h0000; end
    ex.tag = 8'd1;
    ex.er  = {16'hFC00, 16'hFC00, 16'hFC00, 16'hFC00, 16'hFC00, 16'hFC00, 16'hFC00, 16'h1C00};
    ex.ei  = {16'(-2472), 16'hFC00, 16'(-424), 16'h0000, 16'd424, 16'h0400, 16'd2472, 16'h0000};
    ex.tol = {4'd2, 4'd0, 4'd2, 4'd0, 4'd2, 4'd0, 4'd2, 4'd0};
    run_fft(vr, vi, ex);

    // Impulse at n=0: flat spectrum of 1.0.
    vr = '0; vi = '0; vr[0] = 16'h0100;
    run_fft(vr, vi, flat_exp(8'd2, 16'h0100, 16'h0100));

    // Impulse at n=4: X_k = (-1)^k.
    vr = '0; vi = '0; vr[4] = 16'h0100;
    ex.tag = 8'd3;
    ex.er  = {16'hFF00, 16'h0100, 16'hFF00, 16'h0100, 16'hFF00, 16'h0100, 16'hFF00, 16'h0100};
    ex.ei  = '0;
    ex.tol = '0;
    run_fft(vr, vi, ex);

    // DC: all ones -> 8 in bin 0, zero elsewhere.
    for (int n = 0; n < 8; n++) begin vr[n] = 16'h0100; vi[n] = 16'h0000; end
    run_fft(vr, vi, flat_exp(8'd4, 16'h0800, 16'h0000));

    // Wrap: 8 * 127 = 1016 = -8 mod 256, so y0r = 0xF800 without saturation.
    for (int n = 0; n < 8; n++) begin vr[n] = 16'h7F00; vi[n] = 16'h0000; end
    run_fft(vr, vi, flat_exp(8'd5, 16'hF800, 16'h0000));

    // Reset in the middle of COMPUTE aborts and clears y on the next edge.
    for (int n = 0; n < 8; n++) begin xr[n] = 16'h0100; xi[n] = 16'h0000; end
    write = 1'b1;
    tick;
    write = 1'b0; start = 1'b1;
    tick;
    chk("abort_in_compute", 32'(state), 32'd2);
    start = 1'b0;
    tick;
    rst = 1'b1;
    tick;
    chk("abort_state", 32'(state), 32'd0);
    chk("abort_ready", 32'(ready), 32'd0);
    check_y_zero("abort");
    rst = 1'b0;
    tick;

    // Recovery after the abort.
    vr = '0; vi = '0; vr[0] = 16'h0100;
    run_fft(vr, vi, flat_exp(8'd6, 16'h0100, 16'h0100));

    tick;
    tick;
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
